// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg: requester IDs, grant FSM encoding and transfer size codes for sram_like_arbiter.
package sram_like_arbiter_pkg;
  typedef logic id_t;
  localparam id_t ID_INST = 1'b0;
  localparam id_t ID_DATA = 1'b1;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD_I = 2'd1;
  localparam logic [1:0] ST_HOLD_D = 2'd2;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/sram_like_if.sv
// sram_like_if: one SRAM-like req/addr_ok/data_ok port; master issues requests, slave answers them.
interface sram_like_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic                req;
  logic                wr;
  logic [1:0]          size;
  logic [DATA_W/8-1:0] wstrb;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic                addr_ok;
  logic                data_ok;
  logic [DATA_W-1:0]   rdata;
  modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_arbiter_id_fifo.sv
// arb_id_fifo: synchronous FIFO of 1-bit requester IDs recording accepted-but-unanswered bus requests.
module arb_id_fifo #(parameter int DEPTH = 2) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign head  = mem_q[rp_q];
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wp_d    = wp_q + AW'(do_push);
    rp_d    = rp_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wp_q] = din;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like bus between fetch and load/store ports with in-order response routing.
// Define ARB_ROUND_ROBIN_EN for alternating IDLE priority; default is fixed data-over-inst.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(parameter int OUTS_DEPTH = 2) (
  input logic         clk,
  input logic         reset,
  sram_like_if.slave  inst,
  sram_like_if.slave  data,
  sram_like_if.master bus
);
  logic [1:0] state_q, state_d;
  logic idle, gnt_valid, pick, accept, pop, head, full, empty;
  id_t gnt_id;
`ifdef ARB_ROUND_ROBIN_EN
  id_t last_id_q, last_id_d;
  assign pick      = (data.req & inst.req) ? ~last_id_q : data.req;
  assign last_id_d = accept ? gnt_id : last_id_q;
  always_ff @(posedge clk) last_id_q <= reset ? ID_INST : last_id_d;
`else
  assign pick = data.req ? ID_DATA : ID_INST;
`endif
  always_comb begin
    idle      = state_q == ST_IDLE;
    gnt_id    = idle ? pick : (state_q == ST_HOLD_D ? ID_DATA : ID_INST);
    gnt_valid = idle ? ~full : 1'b1;
    bus.req   = ~reset & gnt_valid & (gnt_id == ID_DATA ? data.req : inst.req);
    bus.wr    = gnt_id == ID_DATA ? data.wr    : inst.wr;
    bus.size  = gnt_id == ID_DATA ? data.size  : inst.size;
    bus.wstrb = gnt_id == ID_DATA ? data.wstrb : inst.wstrb;
    bus.addr  = gnt_id == ID_DATA ? data.addr  : inst.addr;
    bus.wdata = gnt_id == ID_DATA ? data.wdata : inst.wdata;
    accept    = bus.req & bus.addr_ok;
    // a dropped request in HOLD falls back to IDLE without pushing
    state_d   = (bus.req & ~bus.addr_ok) ? (gnt_id == ID_DATA ? ST_HOLD_D : ST_HOLD_I) : ST_IDLE;
    pop       = ~reset & bus.data_ok & ~empty;
    inst.addr_ok = accept & gnt_id == ID_INST;
    data.addr_ok = accept & gnt_id == ID_DATA;
    inst.data_ok = pop & head == ID_INST;
    data.data_ok = pop & head == ID_DATA;
    inst.rdata   = bus.rdata;
    data.rdata   = bus.rdata;
  end
  always_ff @(posedge clk) state_q <= reset ? ST_IDLE : state_d;
  arb_id_fifo #(.DEPTH(OUTS_DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (reset),
    .push (accept),
    .pop  (pop),
    .din  (gnt_id),
    .head (head),
    .full (full),
    .empty(empty)
  );
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed-step self-checking bench for sram_like_arbiter.
module tb_sram_like_arbiter;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  sram_like_if inst_if ();
  sram_like_if data_if ();
  sram_like_if bus_if ();
  sram_like_arbiter #(.OUTS_DEPTH(2)) dut (
    .clk  (clk),
    .reset(reset),
    .inst (inst_if.slave),
    .data (data_if.slave),
    .bus  (bus_if.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    reset = 1'b1;
    {inst_if.req, inst_if.wr, inst_if.size, inst_if.wstrb, inst_if.addr, inst_if.wdata} = '0;
    {data_if.req, data_if.wr, data_if.size, data_if.wstrb, data_if.addr, data_if.wdata} = '0;
    bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; bus_if.rdata = '0;
    inst_if.addr = 32'h0000_0200; data_if.addr = 32'h0000_0100;
    inst_if.size = 2'd2; data_if.size = 2'd2;
    cyc();
    inst_if.req = 1'b1; bus_if.addr_ok = 1'b1; bus_if.data_ok = 1'b1; settle();
    chk("rst_bus_req", bus_if.req, 0);
    chk("rst_inst_addr_ok", inst_if.addr_ok, 0);
    chk("rst_inst_data_ok", inst_if.data_ok, 0);
    cyc();
    reset = 1'b0; inst_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b0; settle();
    chk("idle_bus_req", bus_if.req, 0);
    // 1: both request, data first then inst, responses in order
    cyc();
    inst_if.req = 1'b1; data_if.req = 1'b1; bus_if.addr_ok = 1'b1; settle();
    chk("t1_data_addr_ok", data_if.addr_ok, 1);
    chk("t1_inst_addr_ok0", inst_if.addr_ok, 0);
    chk("t1_bus_addr_d", bus_if.addr, 32'h100);
    cyc();
    data_if.req = 1'b0; settle();
    chk("t1_inst_addr_ok", inst_if.addr_ok, 1);
    chk("t1_bus_addr_i", bus_if.addr, 32'h200);
    cyc();
    inst_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; bus_if.rdata = 32'hAAAA; settle();
    chk("t1_data_data_ok", data_if.data_ok, 1);
    chk("t1_inst_data_ok0", inst_if.data_ok, 0);
    chk("t1_data_rdata", data_if.rdata, 32'hAAAA);
    cyc();
    bus_if.rdata = 32'hBBBB; settle();
    chk("t1_inst_data_ok", inst_if.data_ok, 1);
    chk("t1_data_data_ok0", data_if.data_ok, 0);
    chk("t1_inst_rdata", inst_if.rdata, 32'hBBBB);
    cyc();
    // 2: inst held without addr_ok; data arrives but is ignored until inst accepted
    bus_if.data_ok = 1'b0; inst_if.req = 1'b1; settle();
    chk("t2_c0_bus_req", bus_if.req, 1);
    chk("t2_c0_bus_addr", bus_if.addr, 32'h200);
    cyc();
    data_if.req = 1'b1; settle();
    chk("t2_c1_bus_addr", bus_if.addr, 32'h200);
    cyc();
    chk("t2_c2_bus_addr", bus_if.addr, 32'h200);
    cyc();
    bus_if.addr_ok = 1'b1; settle();
    chk("t2_c3_inst_addr_ok", inst_if.addr_ok, 1);
    chk("t2_c3_data_addr_ok", data_if.addr_ok, 0);
    cyc();
    inst_if.req = 1'b0; settle();
    chk("t2_c4_data_addr_ok", data_if.addr_ok, 1);
    chk("t2_c4_bus_addr", bus_if.addr, 32'h100);
    cyc();
    data_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; settle();
    chk("t2_inst_data_ok", inst_if.data_ok, 1);
    cyc();
    chk("t2_data_data_ok", data_if.data_ok, 1);
    cyc();
    // 3: two outstanding fills the FIFO; a pop cycle still blocks a new grant
    bus_if.data_ok = 1'b0; inst_if.req = 1'b1; bus_if.addr_ok = 1'b1; settle();
    chk("t3_acc1", inst_if.addr_ok, 1);
    cyc();
    chk("t3_acc2", inst_if.addr_ok, 1);
    cyc();
    chk("t3_full_bus_req", bus_if.req, 0);
    chk("t3_full_addr_ok", inst_if.addr_ok, 0);
    bus_if.data_ok = 1'b1; settle();
    chk("t3_pop_bus_req", bus_if.req, 0);
    chk("t3_pop_inst_data_ok", inst_if.data_ok, 1);
    cyc();
    bus_if.data_ok = 1'b0; settle();
    chk("t3_after_bus_req", bus_if.req, 1);
    chk("t3_after_addr_ok", inst_if.addr_ok, 1);
    cyc();
    inst_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; settle();
    chk("t3_drain1", inst_if.data_ok, 1);
    cyc();
    chk("t3_drain2", inst_if.data_ok, 1);
    cyc();
    // 4: store passthrough
    bus_if.data_ok = 1'b0;
    data_if.req = 1'b1; data_if.wr = 1'b1; data_if.wstrb = 4'b0011; data_if.size = 2'd1;
    data_if.addr = 32'h1c00_8000; data_if.wdata = 32'hDEAD_BEEF; bus_if.addr_ok = 1'b1; settle();
    chk("t4_bus_wr", bus_if.wr, 1);
    chk("t4_bus_wstrb", bus_if.wstrb, 4'b0011);
    chk("t4_bus_size", bus_if.size, 2'd1);
    chk("t4_bus_addr", bus_if.addr, 32'h1c00_8000);
    chk("t4_bus_wdata", bus_if.wdata, 32'hDEAD_BEEF);
    chk("t4_data_addr_ok", data_if.addr_ok, 1);
    cyc();
    data_if.req = 1'b0; data_if.wr = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; settle();
    chk("t4_data_data_ok", data_if.data_ok, 1);
    cyc();
    // 5: reset in HOLD_D with one outstanding ID
    bus_if.data_ok = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h100; bus_if.addr_ok = 1'b1; settle();
    chk("t5_acc", data_if.addr_ok, 1);
    cyc();
    bus_if.addr_ok = 1'b0;
    cyc();
    reset = 1'b1; bus_if.addr_ok = 1'b1; settle();
    chk("t5_rst_bus_req", bus_if.req, 0);
    chk("t5_rst_addr_ok", data_if.addr_ok, 0);
    cyc();
    reset = 1'b0; data_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; settle();
    chk("t5_stale_data_ok_d", data_if.data_ok, 0);
    chk("t5_stale_data_ok_i", inst_if.data_ok, 0);
    cyc();
    bus_if.data_ok = 1'b0; inst_if.req = 1'b1; bus_if.addr_ok = 1'b1; settle();
    chk("t5_idle_inst_acc", inst_if.addr_ok, 1);
    cyc();
    inst_if.req = 1'b0; bus_if.addr_ok = 1'b0; bus_if.data_ok = 1'b1; settle();
    chk("t5_fifo_head_i", inst_if.data_ok, 1);
    chk("t5_fifo_head_d", data_if.data_ok, 0);
    cyc();
    // 6: both held with addr_ok; one response per cycle keeps the FIFO from filling
    bus_if.data_ok = 1'b0; inst_if.req = 1'b1; data_if.req = 1'b1; bus_if.addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("t6_rr_data_addr_ok%0d", k), data_if.addr_ok, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("t6_rr_inst_addr_ok%0d", k), inst_if.addr_ok, (k % 2 == 1) ? 1 : 0);
`else
      chk($sformatf("t6_fix_data_addr_ok%0d", k), data_if.addr_ok, 1);
      chk($sformatf("t6_fix_inst_addr_ok%0d", k), inst_if.addr_ok, 0);
`endif
      cyc();
      bus_if.data_ok = 1'b1;
    end
    inst_if.req = 1'b0; data_if.req = 1'b0; bus_if.addr_ok = 1'b0; settle();
    chk("t6_drain_any", inst_if.data_ok | data_if.data_ok, 1);
    cyc();
    bus_if.data_ok = 1'b0;
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
